nonogram_stream_parser: RTL
===========================

// Module: nonogram_stream_parser
// PURPOSE
// Parametrised successor of the board parser: consumes the UART byte stream of two-byte messages
// (header flag byte, payload byte), tracks board dims, counts options per line, emits line/option
// words through a valid/ready output FIFO. Sits between UART RX and the option BRAM writer.
// Adds backpressure, per-line length checks, and configurable board/option sizes.
// PARAMETERS
// MAX_ROWS        11  max board rows m
// MAX_COLS        11  max board cols n
// MAX_NUM_OPTIONS 84  max options per line; count saturates here
// OUT_DEPTH       4   output FIFO entries (power of 2, >=2)
// Derived: OPT_W=max(MAX_ROWS,MAX_COLS); LINE_W=$clog2(MAX_ROWS+MAX_COLS); CNT_W=$clog2(MAX_NUM_OPTIONS+1)
// PORTS
// clk              in   1       clock
// rst_n            in   1       async active-low reset
// byte_in          in   8       stream byte
// valid_in         in   1       byte_in valid; consumed when valid_in&&ready_in
// ready_in         out  1       =!fifo_full (one slot free)
// out_data         out  OPT_W   header: line index zero-extended; option: assignment bits
// out_is_header    out  1       1=START_LINE word, 0=option word
// out_valid        out  1       FIFO not empty
// out_ready        in   1       sink accepts head when out_valid&&out_ready
// options_per_line out  (MAX_ROWS+MAX_COLS)xCNT_W  option count per line index
// m                out  $clog2(MAX_ROWS+1)  row count
// n                out  $clog2(MAX_COLS+1)  col count
// board_done       out  1       1-cycle pulse on END_BOARD payload
// first_read       out  1       1-cycle pulse on first option word of a board entering FIFO
// proto_err        out  1       sticky error (only with PARSER_PROTO_CHECK_EN; else tied 0)
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, FIFO empty, phase=HDR, state=IDLE, option reg 0.
// - Phase bit toggles per accepted byte; HDR byte stored, flag=hdr[7:5]; action on PAY byte.
// - Flags: 111 START_BOARD, 110 START_LINE, 101 AND, 010 OR, 001 END_LINE, 000 END_BOARD; others ignored.
// - FSM: IDLE -START_BOARD(pay=n)-> DIM -START_BOARD(pay=m)-> BOARD -START_LINE-> LINE;
//   LINE -END_LINE-> BOARD (line_idx+1); BOARD -END_BOARD-> IDLE (board_done pulse next cycle).
// - START_BOARD also clears line_idx, options_per_line, option reg. Dims from payload[7:0].
// - START_LINE: push {hdr=1, data=line_idx}; option reg<=0; options_per_line[line_idx]<=0.
// - AND: idx=payload[7:1]; option reg[idx]<=payload[0]; no push. idx>=line length ignored.
// - Line length: line_idx<m -> row, length n; else column, length m.
// - OR / END_LINE: push {hdr=0, data=option reg}; option reg<=0; count+1, saturate MAX_NUM_OPTIONS.
// - Push and pop same cycle when full: allowed (pop frees slot); ready_in stays low while full
//   at start of cycle. Push latency: word visible on out_valid cycle after PAY byte accepted.
// - out_data/out_is_header held stable while out_valid&&!out_ready.
// - Messages out of order without check macro: acted on per flag regardless of state.
// - line_idx wraps to 0 past MAX_ROWS+MAX_COLS-1 (no check) ; counts never exceed MAX_NUM_OPTIONS.
// CONFIGURATION
// PARSER_PROTO_CHECK_EN defined: proto_err set (sticky) on flag illegal for state, AND idx>=line
//   length, count overflow, line_idx>=m+n, or dims 0/>MAX; state->ERR, no pushes until next
//   START_BOARD header+payload in any state, which clears proto_err and re-enters DIM.
// Not defined: no ERR state, proto_err=0, checks absent, behaviour as listed above.
// TESTING
// 1 2x2 board: SB n=2, SB m=2, 4 lines each SL,AND(0,1),AND(1,0),EL, EB -> 8 words, hdrs 0..3,
//   options 2'b01, options_per_line all 1, board_done 1 pulse, first_read 1 pulse.
// 2 Line 0 with 3 options via OR,OR,EL -> 3 option words, options_per_line[0]=3.
// 3 out_ready=0 for 20 cycles mid-board -> ready_in low after OUT_DEPTH words, none lost/dup.
// 4 rst_n low between HDR and PAY -> all outputs 0; next bytes parsed as new header.
// 5 (EN) AND idx=12 on 11-col row -> proto_err=1, no further pushes; new SB,SB clears it.
// 6 85 ORs on one line -> options_per_line saturates at 84; (EN) proto_err=1.

Source files
------------

// File: rtl/nonogram_stream_parser.sv
// Nonogram board stream parser: header/payload byte pairs in, line-header and option words out via a FIFO.
// Optional protocol checking (sticky proto_err, ERR state) is enabled by defining PARSER_PROTO_CHECK_EN.
module nonogram_stream_parser #(
  parameter int MAX_ROWS        = 11,
  parameter int MAX_COLS        = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int OUT_DEPTH       = 4,
  localparam int OPT_W   = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS,
  localparam int N_LINES = MAX_ROWS + MAX_COLS,
  localparam int LINE_W  = $clog2(N_LINES),
  localparam int CNT_W   = $clog2(MAX_NUM_OPTIONS + 1),
  localparam int M_W     = $clog2(MAX_ROWS + 1),
  localparam int N_W     = $clog2(MAX_COLS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [OPT_W-1:0]         out_data,
  output logic                     out_is_header,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LINES*CNT_W-1:0] options_per_line,
  output logic [M_W-1:0]           m,
  output logic [N_W-1:0]           n,
  output logic                     board_done,
  output logic                     first_read,
  output logic                     proto_err
);

  localparam int PTR_W     = $clog2(OUT_DEPTH);
  localparam int OPT_IDX_W = $clog2(OPT_W);
  localparam logic [7:0]        OPT_W_B    = 8'(OPT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_NUM_OPTIONS);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(N_LINES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DIM   = 3'd1;
  localparam logic [2:0] S_BOARD = 3'd2;
  localparam logic [2:0] S_LINE  = 3'd3;

  localparam logic [2:0] F_SB  = 3'b111;
  localparam logic [2:0] F_SL  = 3'b110;
  localparam logic [2:0] F_AND = 3'b101;
  localparam logic [2:0] F_OR  = 3'b010;
  localparam logic [2:0] F_EL  = 3'b001;
  localparam logic [2:0] F_EB  = 3'b000;

  logic              phase_q, phase_d;
  logic [2:0]        flag_q, flag_d;
  logic [2:0]        state_q, state_d;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  logic [OPT_W-1:0]  opt_q, opt_d;
  logic [CNT_W-1:0]  cnt_q [N_LINES];
  logic [CNT_W-1:0]  cnt_d [N_LINES];
  logic [M_W-1:0]    m_q, m_d;
  logic [N_W-1:0]    n_q, n_d;
  logic              board_done_q, board_done_d;
  logic              first_read_q, first_read_d;
  logic              first_pend_q, first_pend_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OPT_W:0]    fifo_mem [OUT_DEPTH];
  logic [OPT_W:0]    head, push_word;
  logic              accept, pay_acc, pop, push, full, empty;
  logic [7:0]        and_idx, line_len;
  logic [CNT_W-1:0]  cur_cnt;
  logic              err, drop;

  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign ready_in = !full;
  assign accept   = valid_in && ready_in;
  assign pay_acc  = accept && phase_q;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;
  assign head     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  // Gate with out_valid so stale FIFO contents never show as data (and reset drives 0).
  assign out_data      = out_valid ? head[OPT_W-1:0] : '0;
  assign out_is_header = out_valid && head[OPT_W];

  assign and_idx  = {1'b0, byte_in[7:1]};
  // Rows come first in line order; row lines span n cells, column lines span m.
  assign line_len = (line_idx_q < LINE_W'(m_q)) ? 8'(n_q) : 8'(m_q);
  assign cur_cnt  = cnt_q[line_idx_q];

`ifdef PARSER_PROTO_CHECK_EN
  localparam logic [2:0] S_ERR      = 3'd4;
  localparam logic [7:0] MAX_ROWS_B = 8'(MAX_ROWS);
  localparam logic [7:0] MAX_COLS_B = 8'(MAX_COLS);
  logic proto_err_q, proto_err_d;

  always_comb begin
    err  = 1'b0;
    drop = (state_q == S_ERR) && (flag_q != F_SB);
    if (!drop) begin
      unique case (flag_q)
        F_SB:        err = (byte_in == 8'd0) ||
                           (byte_in > ((state_q == S_DIM) ? MAX_ROWS_B : MAX_COLS_B));
        F_SL:        err = (state_q != S_BOARD) ||
                           ((LINE_W+1)'(line_idx_q) >= (LINE_W+1)'(m_q) + (LINE_W+1)'(n_q));
        F_AND:       err = (state_q != S_LINE) || (and_idx >= line_len);
        F_OR, F_EL:  err = (state_q != S_LINE) || (cur_cnt == CNT_MAX);
        F_EB:        err = (state_q != S_BOARD);
        default:     err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err_q <= 1'b0;
    else        proto_err_q <= proto_err_d;
  end
  assign proto_err = proto_err_q;
`else
  assign err       = 1'b0;
  assign drop      = 1'b0;
  assign proto_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    phase_d      = phase_q;
    flag_d       = flag_q;
    state_d      = state_q;
    line_idx_d   = line_idx_q;
    opt_d        = opt_q;
    cnt_d        = cnt_q;
    m_d          = m_q;
    n_d          = n_q;
    first_pend_d = first_pend_q;
    board_done_d = 1'b0;
    first_read_d = 1'b0;
    push         = 1'b0;
    push_word    = '0;
`ifdef PARSER_PROTO_CHECK_EN
    proto_err_d  = proto_err_q;
    if (pay_acc && err) begin
      state_d     = S_ERR;
      proto_err_d = 1'b1;
    end
`endif
    if (accept) phase_d = !phase_q;
    if (accept && !phase_q) flag_d = byte_in[7:5];

    if (pay_acc && !err && !drop) begin
      unique case (flag_q)
        F_SB: begin
          line_idx_d   = '0;
          opt_d        = '0;
          cnt_d        = '{default: '0};
          first_pend_d = 1'b1;
`ifdef PARSER_PROTO_CHECK_EN
          proto_err_d  = 1'b0;
`endif
          if (state_q == S_DIM) begin
            m_d     = byte_in[M_W-1:0];
            state_d = S_BOARD;
          end else begin
            n_d     = byte_in[N_W-1:0];
            state_d = S_DIM;
          end
        end
        F_SL: begin
          push               = 1'b1;
          push_word          = {1'b1, OPT_W'(line_idx_q)};
          opt_d              = '0;
          cnt_d[line_idx_q]  = '0;
          state_d            = S_LINE;
        end
        F_AND: begin
          if (and_idx < line_len && and_idx < OPT_W_B)
            opt_d[and_idx[OPT_IDX_W-1:0]] = byte_in[0];
        end
        F_OR, F_EL: begin
          push      = 1'b1;
          push_word = {1'b0, opt_q};
          opt_d     = '0;
          if (cur_cnt != CNT_MAX) cnt_d[line_idx_q] = cur_cnt + 1'b1;
          if (first_pend_q) begin
            first_read_d = 1'b1;
            first_pend_d = 1'b0;
          end
          if (flag_q == F_EL) begin
            line_idx_d = (line_idx_q == LAST_LINE) ? '0 : line_idx_q + 1'b1;
            state_d    = S_BOARD;
          end
        end
        F_EB: begin
          state_d      = S_IDLE;
          board_done_d = 1'b1;
        end
        default: ;
      endcase
    end

    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
  end

  // NOTE: the FIFO storage has no reset; pointers define validity and out_data is gated.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_word;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      flag_q       <= '0;
      state_q      <= S_IDLE;
      line_idx_q   <= '0;
      opt_q        <= '0;
      cnt_q        <= '{default: '0};
      m_q          <= '0;
      n_q          <= '0;
      board_done_q <= 1'b0;
      first_read_q <= 1'b0;
      first_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      flag_q       <= flag_d;
      state_q      <= state_d;
      line_idx_q   <= line_idx_d;
      opt_q        <= opt_d;
      cnt_q        <= cnt_d;
      m_q          <= m_d;
      n_q          <= n_d;
      board_done_q <= board_done_d;
      first_read_q <= first_read_d;
      first_pend_q <= first_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  for (genvar i = 0; i < N_LINES; i++) begin : g_opl
    assign options_per_line[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign m          = m_q;
  assign n          = n_q;
  assign board_done = board_done_q;
  assign first_read = first_read_q;

endmodule
